// File: rtl/picorisc_mem_pkg.sv
// picorisc_mem_pkg -- shared types and helpers for the picoRISC load/store path. Rev 1.0
`default_nettype none

package picorisc_mem_pkg;

  typedef enum logic [1:0] {IDLE, STORE, LOAD, ERR} mau_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} mem_size_t;

  // Byte count of an access; the reserved encoding is rejected before this matters.
  function automatic logic [2:0] nbytes(mem_size_t sz);
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// load_extend -- assembles little-endian load bytes and sign/zero-extends to XLEN. Rev 1.0
`default_nettype none

module load_extend
  import picorisc_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0][7:0]  bytes_in,
  input  logic [1:0]       size,
  input  logic             sign,
  output logic [XLEN-1:0]  data
);

  always_comb begin
    data = '0;
    case (mem_size_t'(size))
      SZ_B: begin
        data       = {XLEN{sign & bytes_in[0][7]}};
        data[7:0]  = bytes_in[0];
      end
      SZ_H: begin
        data       = {XLEN{sign & bytes_in[1][7]}};
        data[15:0] = {bytes_in[1], bytes_in[0]};
      end
      default: begin
        data       = {XLEN{sign & bytes_in[3][7]}};
        data[31:0] = bytes_in;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit -- splits CPU loads/stores into byte-wide RAM accesses. Rev 1.0
// Optional build macro MAU_ALIGN_CHECK_EN: also rejects accesses whose addr is not a multiple of N.
`default_nettype none

module mem_access_unit
  import picorisc_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 200,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [7:0]      addr,
  input  logic [XLEN-1:0] wdata,
  output logic            ready,
  output logic            done,
  output logic            rvalid,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            ram_sw,
  output logic [7:0]      ram_addr,
  output logic [7:0]      ram_din,
  input  logic [7:0]      ram_dout
);

  localparam logic [9:0] c_depth = 10'(MEM_DEPTH);

  mau_state_t      r_state;
  logic [2:0]      r_cnt;
  logic [2:0]      r_n;
  logic [7:0]      r_base;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_size;
  logic            r_sign;
  logic [3:0][7:0] r_bytes;
  logic [3:0][7:0] w_ld_bytes;
  logic [2:0]      w_req_n;
  logic [9:0]      w_last;
  logic            w_misalign;
  logic            w_fail;
  logic [1:0]      w_idx;
  logic [1:0]      w_nxt_idx;
  logic [XLEN-1:0] w_ext;

  assign w_req_n = nbytes(mem_size_t'(size));
  assign w_last  = {2'b00, addr} + {7'd0, w_req_n} - 10'd1;

`ifdef MAU_ALIGN_CHECK_EN
  assign w_misalign = (addr[1:0] & (w_req_n[1:0] - 2'd1)) != 2'd0;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fail    = (size == 2'b11) || (w_last >= c_depth) || w_misalign;
  assign w_idx     = r_cnt[1:0] - 2'd1;
  assign w_nxt_idx = r_cnt[1:0] + 2'd1;

  // The final load byte is still on ram_dout when rdata is written, so splice it in here.
  always_comb begin
    w_ld_bytes        = r_bytes;
    w_ld_bytes[w_idx] = ram_dout;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .bytes_in (w_ld_bytes),
    .size     (r_size),
    .sign     (r_sign),
    .data     (w_ext)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_n      <= 3'd0;
      r_base   <= 8'd0;
      r_wdata  <= '0;
      r_size   <= 2'd0;
      r_sign   <= 1'b0;
      r_bytes  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      ram_sw   <= 1'b0;
      ram_addr <= 8'd0;
      ram_din  <= 8'd0;
    end else begin
      done   <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;

      case (r_state)
        STORE: begin
          if (r_cnt == r_n - 3'd1) begin
            r_state <= IDLE;
            ram_sw  <= 1'b0;
            done    <= 1'b1;
            ready   <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + 3'd1;
            ram_addr <= r_base + {5'd0, r_cnt} + 8'd1;
            ram_din  <= r_wdata[{w_nxt_idx, 3'b000} +: 8];
          end
        end
        LOAD: begin
          // Read data lags the address by one cycle, so capture trails issue by one.
          if (r_cnt != 3'd0) r_bytes[w_idx] <= ram_dout;
          if (r_cnt == r_n) begin
            r_state <= IDLE;
            done    <= 1'b1;
            rvalid  <= 1'b1;
            ready   <= 1'b1;
            rdata   <= w_ext;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if ((r_cnt + 3'd1) < r_n) ram_addr <= r_base + {5'd0, r_cnt} + 8'd1;
          end
        end
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Acceptance overrides the state step above so the done cycle can start a new access.
      if (ready && req) begin
        r_base  <= addr;
        r_wdata <= wdata;
        r_size  <= size;
        r_sign  <= sign;
        r_n     <= w_req_n;
        r_cnt   <= 3'd0;
        if (w_fail) begin
          r_state <= ERR;
          done    <= 1'b1;
          err     <= 1'b1;
          ready   <= 1'b1;
        end else begin
          r_state  <= we ? STORE : LOAD;
          ready    <= 1'b0;
          ram_addr <= addr;
          if (we) begin
            ram_sw  <= 1'b1;
            ram_din <= wdata[7:0];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed self-checking bench for mem_access_unit with a byte RAM model. Rev 1.0
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        ram_sw;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [256];
  logic        mem_init = 1'b0;
  logic [31:0] wd;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(200), .XLEN(32)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign     (sign),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .ram_sw   (ram_sw),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Byte RAM with registered read port.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_dout <= 8'h00;
      mem_init <= 1'b1;
    end else begin
      if (ram_sw) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle 1 of the access.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [31:0] d);
    we = w; size = sz; sign = sg; addr = a; wdata = d; req = 1'b1;
    step();
    req = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
    addr = 8'h00; wdata = 32'h0;
    step();
    step();
    check("rst_ready",  ready,    1);
    check("rst_done",   done,     0);
    check("rst_rvalid", rvalid,   0);
    check("rst_err",    err,      0);
    check("rst_sw",     ram_sw,   0);
    check("rst_rdata",  rdata,    0);
    check("rst_addr",   ram_addr, 0);
    @(negedge clk) n_rst = 1'b1;
    step();

    // Word store at 0x10
    wd = 32'hA1B2C3D4;
    issue(1'b1, 2'b10, 1'b0, 8'h10, wd);
    for (int i = 0; i < 4; i++) begin
      check("st_sw",    ram_sw,   1);
      check("st_addr",  ram_addr, 32'h10 + i);
      check("st_din",   ram_din,  wd[8*i +: 8]);
      check("st_ready", ready,    0);
      check("st_done",  done,     0);
      step();
    end
    check("st_done5",   done,   1);
    check("st_sw5",     ram_sw, 0);
    check("st_ready5",  ready,  1);
    check("st_rvalid5", rvalid, 0);
    check("st_err5",    err,    0);
    for (int i = 0; i < 4; i++) check("st_mem", mem[16 + i], wd[8*i +: 8]);
    step();
    check("st_done_pulse", done, 0);

    // Byte load, signed then unsigned
    issue(1'b0, 2'b00, 1'b1, 8'h13, 32'h0);
    check("lb_addr",  ram_addr, 8'h13);
    check("lb_sw",    ram_sw,   0);
    check("lb_ready", ready,    0);
    step();
    check("lb_rvalid2", rvalid, 0);
    step();
    check("lb_rvalid3", rvalid, 1);
    check("lb_done3",   done,   1);
    check("lb_rdata_s", rdata,  32'hFFFFFFA1);
    step();
    issue(1'b0, 2'b00, 1'b0, 8'h13, 32'h0);
    step();
    step();
    check("lbu_rvalid", rvalid, 1);
    check("lbu_rdata",  rdata,  32'h000000A1);
    step();

    // Half load at 0x11, then a back-to-back byte load from the done cycle
    issue(1'b0, 2'b01, 1'b0, 8'h11, 32'h0);
    step();
    step();
    check("lh_rvalid3", rvalid, 0);
    step();
    check("lh_rvalid4", rvalid, 1);
    check("lh_rdata",   rdata,  32'h0000B2C3);
    check("lh_ready4",  ready,  1);
    issue(1'b0, 2'b00, 1'b1, 8'h10, 32'h0);
    check("b2b_ready", ready,    0);
    check("b2b_addr",  ram_addr, 8'h10);
    check("b2b_done",  done,     0);
    check("b2b_hold",  rdata,    32'h0000B2C3);
    step();
    step();
    check("b2b_rvalid", rvalid, 1);
    check("b2b_rdata",  rdata,  32'hFFFFFFD4);
    step();

    // Signed half load
    issue(1'b0, 2'b01, 1'b1, 8'h12, 32'h0);
    step();
    step();
    step();
    check("lhs_rdata", rdata, 32'hFFFFA1B2);
    step();

    // Range and size rejection
    issue(1'b0, 2'b10, 1'b0, 8'd197, 32'h0);
    check("rng_err",    err,      1);
    check("rng_done",   done,     1);
    check("rng_rvalid", rvalid,   0);
    check("rng_sw",     ram_sw,   0);
    check("rng_ready",  ready,    1);
    check("rng_rdata",  rdata,    32'hFFFFA1B2);
    check("rng_addr",   ram_addr, 8'h13);
    step();
    check("rng_err_pulse", err, 0);
    issue(1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
    check("rsv_err",  err,  1);
    check("rsv_done", done, 1);
    step();
    issue(1'b0, 2'b00, 1'b0, 8'd200, 32'h0);
    check("b200_err", err, 1);
    step();
    issue(1'b0, 2'b10, 1'b0, 8'd196, 32'h0);
    check("w196_err",   err,   0);
    check("w196_ready", ready, 0);
    for (int i = 0; i < 5; i++) step();
    check("w196_rvalid", rvalid, 1);
    check("w196_rdata",  rdata,  32'h0);
    step();

    // Misaligned word store at 0x11
    issue(1'b1, 2'b10, 1'b0, 8'h11, 32'h55667788);
`ifdef MAU_ALIGN_CHECK_EN
    check("mis_err",  err,    1);
    check("mis_done", done,   1);
    check("mis_sw",   ram_sw, 0);
    step();
    check("mis_mem", mem[8'h11], 8'hC3);
`else
    check("mis_err", err,    0);
    check("mis_sw",  ram_sw, 1);
    for (int i = 0; i < 4; i++) step();
    check("mis_done", done, 1);
    check("mis_m11", mem[8'h11], 8'h88);
    check("mis_m12", mem[8'h12], 8'h77);
    check("mis_m13", mem[8'h13], 8'h66);
    check("mis_m14", mem[8'h14], 8'h55);
`endif
    step();

    // Reset in cycle 2 of a word store
    issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344);
    step();
    n_rst = 1'b0;
    #1;
    check("rmid_sw",    ram_sw,   0);
    check("rmid_ready", ready,    1);
    check("rmid_done",  done,     0);
    check("rmid_err",   err,      0);
    check("rmid_addr",  ram_addr, 0);
    check("rmid_din",   ram_din,  0);
    check("rmid_rdata", rdata,    0);
    step();
    step();
    @(negedge clk) n_rst = 1'b1;
    step();
    check("rrel_ready", ready, 1);
    check("rrel_sw",    ram_sw, 0);
    check("rrel_m20",   mem[8'h20], 8'h44);
    check("rrel_m21",   mem[8'h21], 8'h00);
    check("rrel_m22",   mem[8'h22], 8'h00);
    check("rrel_m23",   mem[8'h23], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
